// File: rtl/pixel_feeder.sv
// Streams a latched binary pixel vector as Q8.24 beats with a valid/ready handshake.
// Define PIXEL_FEEDER_SKIP_ZERO_EN to suppress beats for zero pixels.
module pixel_feeder #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned IWIDTH = 64,
  parameter int unsigned AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IWIDTH-1:0] pix_vec,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH-1:0] out_idx,
  output logic              out_last
);

  localparam logic [DWIDTH-1:0] ONE_Q     = DWIDTH'(32'h0100_0000);
  localparam logic [AWIDTH-1:0] LAST_IDX  = AWIDTH'(IWIDTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state, state_d;
  logic [AWIDTH-1:0] cnt, cnt_d;
  logic [IWIDTH-1:0] pix, pix_d;

  logic              cur_valid, cur_last, accept;
  logic              nxt_valid, nxt_last, in_stream_d;
  logic              busy_d, done_d, valid_d, last_d;
  logic [DWIDTH-1:0] data_d;
  logic [AWIDTH-1:0] idx_d;

  // State, counter, pixel register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pix       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pix       <= pix_d;
      busy      <= busy_d;
      done      <= done_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_idx   <= idx_d;
      out_last  <= last_d;
    end
  end

  // Next state plus next-cycle output values derived from it
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pix_d     = pix;
`ifdef PIXEL_FEEDER_SKIP_ZERO_EN
    cur_valid = (state == STREAM) && pix[cnt];
    cur_last  = ((pix >> cnt) >> 1) == '0;
`else
    cur_valid = (state == STREAM);
    cur_last  = (cnt == LAST_IDX);
`endif
    accept    = cur_valid && out_ready;

    unique case (state)
      IDLE: begin
        if (start) begin
          pix_d   = pix_vec;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          if (cur_last) state_d = DONE;
          else          cnt_d   = cnt + AWIDTH'(1);
        end else if (!cur_valid) begin
          // Zero pixel in skip mode: walk past it without a beat
          if (cnt == LAST_IDX) state_d = DONE;
          else                 cnt_d   = cnt + AWIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef PIXEL_FEEDER_SKIP_ZERO_EN
    nxt_valid = pix_d[cnt_d];
    nxt_last  = ((pix_d >> cnt_d) >> 1) == '0;
`else
    nxt_valid = 1'b1;
    nxt_last  = (cnt_d == LAST_IDX);
`endif
    in_stream_d = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    valid_d     = in_stream_d && nxt_valid;
    last_d      = in_stream_d && nxt_valid && nxt_last;
    data_d      = (in_stream_d && pix_d[cnt_d]) ? ONE_Q : '0;
    idx_d       = in_stream_d ? cnt_d : '0;
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// Scoreboard bench for pixel_feeder: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pixel_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 64;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [IW-1:0] pix_vec;
  logic          busy, done, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t prev_beat, got_beat;
  logic  stall_prev = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    done_seen = 0;

  pixel_feeder #(.DWIDTH(DW), .IWIDTH(IW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_vec(pix_vec),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: handshake beats against the scoreboard, held beats for stability, done pulses
  always @(negedge clk) begin
    if (done) done_seen++;
    if (out_valid) begin
      got_beat = '{data: out_data, idx: out_idx, last: out_last};
      if (stall_prev) check("held_beat_stable", 64'(got_beat), 64'(prev_beat));
      if (out_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_idx), 64'hFFFF);
        end else begin
          prev_beat = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(prev_beat.data));
          check("beat_idx",  64'(out_idx),  64'(prev_beat.idx));
          check("beat_last", 64'(out_last), 64'(prev_beat.last));
        end
      end
    end
    stall_prev = out_valid && !out_ready && rst_n;
    prev_beat  = '{data: out_data, idx: out_idx, last: out_last};
  end

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"},  64'(out_data),  64'd0);
    check({tag, "_idx"},   64'(out_idx),   64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
  endtask

  // One image: push expectations, pulse start, run to done with optional ready toggling / restart attempt
  task automatic run_stream(input logic [IW-1:0] vec, input bit toggle, input bit restart_mid);
    int    hi = -1;
    int    nexp = 0;
    int    n = 0;
    int    exp_cycles;
    int    base_beats, base_done;
    bit    got = 1'b0;
    beat_t b;
    for (int i = 0; i < int'(IW); i++) if (vec[i]) hi = i;
    for (int i = 0; i < int'(IW); i++) begin
`ifdef PIXEL_FEEDER_SKIP_ZERO_EN
      if (!vec[i]) continue;
      b.last = (i == hi);
`else
      b.last = (i == int'(IW) - 1);
`endif
      b.data = vec[i] ? 32'h0100_0000 : 32'h0;
      b.idx  = AW'(i);
      exp_q.push_back(b);
      nexp++;
    end
`ifdef PIXEL_FEEDER_SKIP_ZERO_EN
    exp_cycles = (hi < 0) ? int'(IW) + 1 : hi + 2;
`else
    exp_cycles = int'(IW) + 1;
`endif
    base_beats = beats_seen;
    base_done  = done_seen;
    start = 1'b1; pix_vec = vec; out_ready = 1'b1;
    while (n < 400 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
      end
      if (toggle) out_ready = n[0];
      if (restart_mid && n == 10) begin start = 1'b1; pix_vec = ~vec; end
      if (restart_mid && n == 11) start = 1'b0;
      if (done) got = 1'b1;
    end
    out_ready = 1'b1;
    check("done_reached", 64'(got), 64'd1);
    if (!toggle) check("done_latency", 64'(n), 64'(exp_cycles));
    check("done_cycle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    check("beat_count", 64'(beats_seen - base_beats), 64'(nexp));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("done_pulses", 64'(done_seen - base_done), 64'd1);
  endtask

  // Reset asserted while idx 20 is presented; stream must be abandoned silently
  task automatic reset_mid_stream();
    int n = 0;
    int base_done;
    start = 1'b1; pix_vec = '1; out_ready = 1'b1;
    for (int i = 0; i < int'(IW); i++)
      exp_q.push_back('{data: 32'h0100_0000, idx: AW'(i), last: (i == int'(IW) - 1)});
    while (n < 200 && !(out_valid && out_idx == AW'(20))) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    check("reached_idx20", 64'(out_idx), 64'd20);
    base_done = done_seen;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_quiet("mid_reset");
    rst_n = 1'b1;
    exp_q.delete();
    repeat (70) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_seen - base_done), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; pix_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("idle");
    run_stream(64'h1, 1'b0, 1'b0);
    run_stream(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0);
    run_stream(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    reset_mid_stream();
    run_stream(64'h5, 1'b0, 1'b0);
`ifdef PIXEL_FEEDER_SKIP_ZERO_EN
    run_stream(64'h8000_0000_0000_0011, 1'b0, 1'b0);
    run_stream(64'h0, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, giving the width of the output data word.
REQ-002 SHALL have parameter IWIDTH, default 64, giving the number of binary pixels per image vector; it is a power of two.
REQ-003 SHALL have parameter AWIDTH, default 6, giving the pixel index width; AWIDTH equals log2(IWIDTH).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to stream a new image.
REQ-007 SHALL have port pix_vec, input, IWIDTH bits: binary pixels; bit i is pixel i.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data, out_idx and out_last are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream MAC accepts the current beat.
REQ-012 SHALL have port out_data, output, DWIDTH bits: pixel converted to Q8.24 (1 -> 32'h01000000, 0 -> 32'h00000000).
REQ-013 SHALL have port out_idx, output, AWIDTH bits: pixel index of the current beat, used as the weight address.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final beat of the image.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-016 In IDLE, start=1 SHALL latch pix_vec into an internal register, clear the counter cnt to 0 and move to STREAM on the next edge.
REQ-017 start SHALL be ignored while in STREAM or DONE; pix_vec changes after the start cycle SHALL have no effect.
REQ-018 In STREAM, without the configuration macro: out_valid=1, out_data=convert(pix[cnt]), out_idx=cnt, out_last=(cnt==IWIDTH-1).
REQ-019 The block SHALL accept a beat only on out_valid && out_ready; on acceptance cnt increments, and when out_last is also high the FSM moves to DONE.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-021 The first beat SHALL be valid in the cycle after start is accepted; with out_ready held at 1, the block SHALL sustain one beat per cycle.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in IDLE is accepted again in the cycle immediately after DONE.
REQ-023 cnt SHALL be AWIDTH bits wide and never wraps, because the FSM leaves STREAM at index IWIDTH-1.
REQ-024 out_valid, out_data, out_idx and out_last SHALL be 0 outside STREAM.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, cnt=0 and the pixel register to 0, at any time including mid-stream.
REQ-026 After reset, all of busy, done, out_valid, out_data, out_idx and out_last SHALL read 0.
REQ-027 A stream interrupted by reset SHALL be abandoned and SHALL produce no done pulse.

Configuration
REQ-028 Macro PIXEL_FEEDER_SKIP_ZERO_EN SHALL select zero-pixel skipping.
REQ-029 Without the macro, all IWIDTH pixels SHALL be emitted as beats, zeros included.
REQ-030 With the macro: in STREAM, out_valid=pix[cnt]; a zero pixel SHALL advance cnt one step per cycle without emitting a beat.
REQ-031 With the macro: out_last=1 only on the highest-indexed set pixel, i.e. when no set pixel lies above cnt.
REQ-032 With the macro: DONE SHALL be entered after the out_last beat is accepted; if the latched vector is all zero, no beat is emitted and DONE is entered after IWIDTH STREAM cycles.

Verification
REQ-033 Reset then idle -> all outputs 0; start with pix_vec=64'h1, out_ready=1 -> 64 beats, idx 0..63, beat 0 data=32'h01000000, all others 0, last on idx 63, done 65 cycles after start.
REQ-034 pix_vec=64'hAAAA_AAAA_AAAA_AAAA, out_ready toggling 1/0 -> data alternates 0/32'h01000000 by idx; held beats stable; exactly 64 accepted beats.
REQ-035 start pulsed again mid-stream with a different pix_vec -> ignored; streamed data matches the first vector.
REQ-036 rst_n=0 at idx 20 -> next cycle IDLE, all outputs 0, no done; a new start afterwards streams from idx 0.
REQ-037 SKIP_ZERO_EN defined, pix_vec=64'h8000_0000_0000_0011 -> beats at idx 0, 4, 63 only, last on 63; all-zero vector -> no beats, done after 64 STREAM cycles.
